// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: wall/bean/over layers plus NSPR double-buffered sprites,
// with per-sprite oriented ROM addressing, colour-key transparency and sprite-0 collision flag.
module sprite_compositor #(
  parameter int          NSPR     = 4,
  parameter int          SPR_LOG2 = 5,
  parameter logic [11:0] KEY      = 12'h000,
  parameter logic [11:0] WALL_C   = 12'hfff,
  parameter logic [11:0] BEAN_C   = 12'hff0,
  parameter logic [11:0] BG_C     = 12'h000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid,
  input  logic [9:0]                   col_addr,
  input  logic [8:0]                   row_addr,
  input  logic                         frame_start,
  input  logic [NSPR*10-1:0]           spr_x,
  input  logic [NSPR*9-1:0]            spr_y,
  input  logic [NSPR*2-1:0]            spr_dir,
  input  logic [NSPR-1:0]              spr_en,
  input  logic                         is_wall,
  input  logic                         is_bean,
  input  logic                         over,
  output logic [NSPR*2*SPR_LOG2-1:0]   rom_addr,
  input  logic [NSPR*12-1:0]           rom_data,
  output logic [11:0]                  pix_out,
  output logic                         pix_out_valid,
  output logic                         collide
);

  localparam int SPR_W = 1 << SPR_LOG2;
  localparam int AW    = 2 * SPR_LOG2;

  // shadow copies of the live sprite state, swapped only at frame_start
  logic [9:0] sx_q   [NSPR];
  logic [8:0] sy_q   [NSPR];
  logic [1:0] sdir_q [NSPR];
  logic [NSPR-1:0] sen_q;

  // stage 1
  logic [NSPR-1:0]    hit_d, hit_q;
  logic [NSPR*AW-1:0] rom_addr_d, rom_addr_q;
  logic               wall_q, bean_q, over_q, vld_q;

  // stage 2
  logic [NSPR-1:0] opaque;
  logic [11:0]     pix_d, pix_q;
  logic            pvld_q, acc_set, acc_q, collide_q;

  for (genvar k = 0; k < NSPR; k++) begin : g_spr
    logic [10:0]         col_e, x_e, x_end;
    logic [9:0]          row_e, y_e, y_end;
    logic [SPR_LOG2-1:0] ox, oy;
    logic [AW-1:0]       addr;

    // widened compare keeps x+SPR_W from wrapping, so right/bottom edges clip
    assign col_e = {1'b0, col_addr};
    assign x_e   = {1'b0, sx_q[k]};
    assign x_end = x_e + 11'(SPR_W);
    assign row_e = {1'b0, row_addr};
    assign y_e   = {1'b0, sy_q[k]};
    assign y_end = y_e + 10'(SPR_W);

    assign hit_d[k] = sen_q[k] && (col_e >= x_e) && (col_e < x_end)
                      && (row_e >= y_e) && (row_e < y_end);

    assign ox = col_addr[SPR_LOG2-1:0] - sx_q[k][SPR_LOG2-1:0];
    assign oy = row_addr[SPR_LOG2-1:0] - sy_q[k][SPR_LOG2-1:0];

    // SPR_W-1-offset equals the bitwise inverse of the offset
    always_comb begin
      addr = '0;
      case (sdir_q[k])
        2'b00: addr = {ox, oy};
        2'b01: addr = {ox, ~oy};
        2'b10: addr = {oy, ox};
        2'b11: addr = {oy, ~ox};
        default: addr = '0;
      endcase
    end

    assign rom_addr_d[k*AW +: AW] = hit_d[k] ? addr : rom_addr_q[k*AW +: AW];
    assign opaque[k] = hit_q[k] && (rom_data[k*12 +: 12] != KEY);
  end

  always_comb begin
    pix_d = BG_C;
    for (int k = NSPR - 1; k >= 0; k--) begin
      if (opaque[k]) pix_d = rom_data[k*12 +: 12];
    end
    if (is_bean_q_sel()) pix_d = BEAN_C;
    if (wall_q) pix_d = WALL_C;
    if (over_q) pix_d = 12'h000;
  end

  function automatic logic is_bean_q_sel();
    return bean_q;
  endfunction

  assign acc_set = vld_q && !over_q && opaque[0] && (|opaque[NSPR-1:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSPR; k++) begin
        sx_q[k]   <= '0;
        sy_q[k]   <= '0;
        sdir_q[k] <= '0;
      end
      sen_q      <= '0;
      hit_q      <= '0;
      rom_addr_q <= '0;
      wall_q     <= 1'b0;
      bean_q     <= 1'b0;
      over_q     <= 1'b0;
      vld_q      <= 1'b0;
      pix_q      <= 12'h000;
      pvld_q     <= 1'b0;
      acc_q      <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      if (frame_start) begin
        for (int k = 0; k < NSPR; k++) begin
          sx_q[k]   <= spr_x[k*10 +: 10];
          sy_q[k]   <= spr_y[k*9 +: 9];
          sdir_q[k] <= spr_dir[k*2 +: 2];
        end
        sen_q <= spr_en;
      end
      hit_q      <= hit_d;
      rom_addr_q <= rom_addr_d;
      wall_q     <= is_wall;
      bean_q     <= is_bean;
      over_q     <= over;
      vld_q      <= pix_valid;
      pix_q      <= pix_d;
      pvld_q     <= vld_q;
      // a hit coinciding with frame_start belongs to the frame that is starting
      if (frame_start) begin
        collide_q <= acc_q;
        acc_q     <= acc_set;
      end else begin
        acc_q <= acc_q | acc_set;
      end
    end
  end

  assign rom_addr      = rom_addr_q;
  assign pix_out       = pix_q;
  assign pix_out_valid = pvld_q;
  assign collide       = collide_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reset, double buffering, orientation,
// priority/transparency, edge clipping, collision timing and mid-frame reset.
module tb_sprite_compositor;

  localparam int NSPR = 4;
  localparam int SW   = 32;
  localparam logic [11:0] KEY    = 12'h000;
  localparam logic [11:0] WALL_C = 12'hfff;
  localparam logic [11:0] BEAN_C = 12'hff0;
  localparam logic [11:0] BG_C   = 12'h000;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid, frame_start, is_wall, is_bean, over;
  logic [9:0]        col_addr;
  logic [8:0]        row_addr;
  logic [NSPR*10-1:0] spr_x;
  logic [NSPR*9-1:0]  spr_y;
  logic [NSPR*2-1:0]  spr_dir;
  logic [NSPR-1:0]    spr_en;
  logic [NSPR*10-1:0] rom_addr;
  logic [NSPR*12-1:0] rom_data;
  logic [11:0]        pix_out;
  logic               pix_out_valid, collide;

  logic [9:0]  lx [NSPR];
  logic [8:0]  ly [NSPR];
  logic [1:0]  ldir [NSPR];
  logic        len [NSPR];
  logic [11:0] rom_c [NSPR];

  int m_x [NSPR];
  int m_y [NSPR];
  bit m_en [NSPR];

  logic [11:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  sprite_compositor dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .col_addr(col_addr), .row_addr(row_addr),
    .frame_start(frame_start), .spr_x(spr_x), .spr_y(spr_y), .spr_dir(spr_dir), .spr_en(spr_en),
    .is_wall(is_wall), .is_bean(is_bean), .over(over), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_out(pix_out), .pix_out_valid(pix_out_valid), .collide(collide)
  );

  always #5 clk = ~clk;

  always_comb begin
    spr_x = '0; spr_y = '0; spr_dir = '0; spr_en = '0; rom_data = '0;
    for (int k = 0; k < NSPR; k++) begin
      spr_x[k*10 +: 10]   = lx[k];
      spr_y[k*9 +: 9]     = ly[k];
      spr_dir[k*2 +: 2]   = ldir[k];
      spr_en[k]           = len[k];
      rom_data[k*12 +: 12] = rom_c[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(int c, int r, bit w, bit b, bit o);
    if (o) return 12'h000;
    if (w) return WALL_C;
    if (b) return BEAN_C;
    for (int k = 0; k < NSPR; k++) begin
      if (m_en[k] && c >= m_x[k] && c < m_x[k] + SW && r >= m_y[k] && r < m_y[k] + SW
          && rom_c[k] != KEY)
        return rom_c[k];
    end
    return BG_C;
  endfunction

  task automatic drive_pix(input int c, input int r, input bit w, input bit b, input bit o);
    @(negedge clk);
    col_addr = 10'(c); row_addr = 9'(r);
    is_wall = w; is_bean = b; over = o;
    pix_valid = 1'b1; frame_start = 1'b0;
    exp_q.push_back(model(c, r, w, b, o));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0; frame_start = 1'b0;
      is_wall = 1'b0; is_bean = 1'b0; over = 1'b0;
    end
  endtask

  task automatic do_frame();
    @(negedge clk);
    pix_valid = 1'b0; frame_start = 1'b1;
    for (int k = 0; k < NSPR; k++) begin
      m_x[k] = int'(lx[k]); m_y[k] = int'(ly[k]); m_en[k] = len[k];
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NSPR; k++) begin
      m_x[k] = 0; m_y[k] = 0; m_en[k] = 1'b0;
    end
  endtask

  // scoreboard: every valid output pixel consumes one expected colour
  always @(negedge clk) begin
    if (rst === 1'b0 && pix_out_valid === 1'b1) begin
      check("exp_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("pix_out", 32'(pix_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [9:0] exp_addr [4];
    exp_addr[0] = 10'd34; exp_addr[1] = 10'd61; exp_addr[2] = 10'd65; exp_addr[3] = 10'd94;

    // reset with random inputs
    rst = 1'b1;
    repeat (2) begin
      col_addr = 10'($urandom_range(0, 1023)); row_addr = 9'($urandom_range(0, 511));
      pix_valid = 1'($urandom_range(0, 1)); frame_start = 1'($urandom_range(0, 1));
      is_wall = 1'($urandom_range(0, 1)); is_bean = 1'($urandom_range(0, 1));
      over = 1'($urandom_range(0, 1));
      for (int k = 0; k < NSPR; k++) begin
        lx[k] = 10'($urandom_range(0, 639)); ly[k] = 9'($urandom_range(0, 479));
        ldir[k] = 2'($urandom_range(0, 3)); len[k] = 1'($urandom_range(0, 1));
        rom_c[k] = 12'($urandom_range(0, 4095));
      end
      @(negedge clk);
    end
    rst = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
    is_wall = 1'b0; is_bean = 1'b0; over = 1'b0;
    for (int k = 0; k < NSPR; k++) begin
      lx[k] = '0; ly[k] = '0; ldir[k] = '0; len[k] = 1'b0;
    end
    rom_c[0] = 12'hf00; rom_c[1] = 12'h0f0; rom_c[2] = 12'h00f; rom_c[3] = 12'habc;
    clear_model();
    check("rst_pix_out", 32'(pix_out), 0);
    check("rst_pix_out_valid", 32'(pix_out_valid), 0);
    check("rst_collide", 32'(collide), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);

    // latency: first valid pixel exactly two cycles after pix_valid
    drive_pix(5, 5, 0, 0, 0);
    idle(1);
    check("latency_n1_valid", 32'(pix_out_valid), 0);
    idle(1);
    check("latency_n2_valid", 32'(pix_out_valid), 1);
    idle(2);

    // double buffer
    lx[0] = 10'd100; ly[0] = 9'd50; len[0] = 1'b1; ldir[0] = 2'd0;
    do_frame();
    idle(1);
    lx[0] = 10'd300;
    drive_pix(110, 50, 0, 0, 0);
    drive_pix(310, 50, 0, 0, 0);
    idle(3);
    do_frame();
    drive_pix(310, 50, 0, 0, 0);
    drive_pix(110, 50, 0, 0, 0);
    idle(3);

    // orientation
    lx[0] = 10'd64; ly[0] = 9'd64;
    for (int d = 0; d < 4; d++) begin
      ldir[0] = 2'(d);
      do_frame();
      drive_pix(65, 66, 0, 0, 0);
      idle(1);
      check($sformatf("orient_dir%0d_rom_addr", d), 32'(rom_addr[9:0]), 32'(exp_addr[d]));
      idle(2);
    end

    // priority and transparency
    lx[0] = 10'd200; ly[0] = 9'd100; ldir[0] = 2'd0;
    lx[1] = 10'd210; ly[1] = 9'd100; ldir[1] = 2'd0; len[1] = 1'b1;
    do_frame();
    rom_c[0] = KEY;
    drive_pix(215, 105, 0, 0, 0);
    idle(3);
    rom_c[0] = 12'hf00;
    drive_pix(215, 105, 0, 0, 0);
    drive_pix(215, 105, 0, 1, 0);
    drive_pix(215, 105, 0, 0, 1);
    drive_pix(215, 105, 1, 0, 0);
    idle(3);
    do_frame();
    idle(1);
    check("collide_after_priority", 32'(collide), 1);

    // edge clip, dir 2 so the address is oy*32+ox
    len[1] = 1'b0;
    lx[0] = 10'd620; ly[0] = 9'd200; ldir[0] = 2'd2;
    do_frame();
    drive_pix(639, 205, 0, 0, 0);
    idle(1);
    check("clip_rom_addr", 32'(rom_addr[9:0]), 32'd179);
    for (int c = 0; c < 12; c++) drive_pix(c, 205, 0, 0, 0);
    idle(1);
    check("clip_no_wrap_addr_hold", 32'(rom_addr[9:0]), 32'd179);
    idle(2);

    // collision
    lx[0] = 10'd100; ly[0] = 9'd100; ldir[0] = 2'd0;
    lx[2] = 10'd131; ly[2] = 9'd100; len[2] = 1'b1;
    do_frame();
    idle(1);
    check("collide_clip_frame", 32'(collide), 0);
    drive_pix(131, 110, 0, 0, 0);
    idle(3);
    do_frame();
    idle(1);
    check("collide_overlap_frame", 32'(collide), 1);
    drive_pix(120, 110, 0, 0, 0);
    idle(3);
    do_frame();
    idle(1);
    check("collide_clear_frame", 32'(collide), 0);
    drive_pix(131, 110, 0, 0, 0);
    do_frame();
    idle(1);
    check("collide_same_cycle_deferred", 32'(collide), 0);
    idle(2);
    do_frame();
    idle(1);
    check("collide_same_cycle_reported", 32'(collide), 1);
    idle(2);

    // mid-frame reset flushes the pipeline
    @(negedge clk);
    col_addr = 10'd131; row_addr = 9'd110; pix_valid = 1'b1; frame_start = 1'b0;
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b0;
    @(negedge clk);
    check("midrst_pix_out_valid", 32'(pix_out_valid), 0);
    check("midrst_pix_out", 32'(pix_out), 0);
    check("midrst_collide", 32'(collide), 0);
    check("midrst_rom_addr", 32'(rom_addr), 0);
    rst = 1'b0;
    for (int k = 0; k < NSPR; k++) len[k] = 1'b0;
    clear_model();
    drive_pix(131, 110, 0, 0, 0);
    idle(3);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Pipelined, parametrised pixel compositor for the VGA path. It merges wall, bean and up to NSPR sprite layers into one 12-bit colour per pixel. Sprite positions are double-buffered per frame, so moves never tear mid-frame. Each sprite gets its own ROM address with 4-way orientation, colour-key transparency is applied, and per-frame sprite-0 collisions are detected. It sits between the maze/bean lookups and the vgac `d_in` port, replacing the fixed two-sprite combinational mux.

## Interface
- NSPR, 4: number of sprites; index 0 is the player; lower index has higher priority.
- SPR_LOG2, 5: log2 of sprite edge length; sprites are square, SPR_W = 2^SPR_LOG2.
- KEY, 12'h000: transparent colour key.
- WALL_C, 12'hfff: wall colour.
- BEAN_C, 12'hff0: bean colour.
- BG_C, 12'h000: background colour.
- clk  in  1  pixel-domain clock; the same clock drives vgac.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  col_addr/row_addr carry a visible pixel request.
- col_addr  in  10  pixel column.
- row_addr  in  9  pixel row.
- frame_start  in  1  one-cycle pulse in vertical blank.
- spr_x  in  NSPR*10  live sprite X; sprite k uses bits [10k+9:10k].
- spr_y  in  NSPR*9  live sprite Y.
- spr_dir  in  NSPR*2  orientation per sprite.
- spr_en  in  NSPR  sprite visible.
- is_wall, is_bean, over  in  1 each  layer flags for the current col_addr/row_addr.
- rom_addr  out  NSPR*2*SPR_LOG2  registered ROM address per sprite.
- rom_data  in  NSPR*12  asynchronous ROM data returned for rom_addr.
- pix_out  out  12  composited colour.
- pix_out_valid  out  1  pix_valid delayed to align with pix_out.
- collide  out  1  sprite 0 overlapped another opaque sprite during the previous frame.

## Operation
- **Shadow registers.** Each sprite has shadow x, y, dir and en registers, loaded from the live inputs only on frame_start. All hit tests use the shadows.
  - A frame_start cycle's own pixel uses the old shadows.
  - Live-input changes between frame_start pulses have no effect.
- **Stage 1**, registered at the end of input cycle N:
  - Per-sprite hit: en && col >= x && col < x+SPR_W && row >= y && row < y+SPR_W. Compute in 11-bit (column) and 10-bit (row) width so that x+SPR_W never wraps; sprites partly off-screen clip.
  - Offsets: ox = (col-x)[SPR_LOG2-1:0], oy = (row-y)[SPR_LOG2-1:0]. Mirror = SPR_W-1-offset; 32-offset is forbidden because it overflows.
  - Address by dir:
    - 00: ox*SPR_W+oy
    - 01: ox*SPR_W+(SPR_W-1-oy)
    - 10: oy*SPR_W+ox
    - 11: oy*SPR_W+(SPR_W-1-ox)
  - A non-hit sprite's address holds its previous value.
  - is_wall, is_bean, over, pix_valid and the hit vector are delayed alongside.
- **Stage 2**, registered at the end of cycle N+1. opaque[k] = hit[k] && rom_data[k] != KEY. pix_out priority:
  1. over → 12'h000
  2. is_wall → WALL_C
  3. is_bean → BEAN_C
  4. lowest k with opaque[k] → rom_data[k]
  5. else BG_C
- **Collision.** The acc flag sets on any stage-2 cycle with pix_valid delayed && !over && opaque[0] && any opaque[k], k≥1. Walls and beans do not mask it.
  - On frame_start: collide ← acc, and acc clears.
  - If an accumulate and frame_start fall in the same cycle, the new hit lands in the cleared acc and counts for the next frame.

## Timing
- Latency is 2 cycles: inputs sampled at edge N appear on pix_out and pix_out_valid in cycle N+2. Throughput is one pixel per clock, with no stalls.
- rom_addr is valid in cycle N+1. The ROM is combinational and is sampled at the end of N+1.
- pix_valid low propagates as pix_out_valid low. pix_out is still computed but is don't-care.
- On reset all of the following are 0, and the first pipelined output is valid two cycles after release:
  - shadows (x, y, dir, en)
  - rom_addr
  - pipeline flags
  - pix_out (12'h000)
  - pix_out_valid
  - acc
  - collide
- rst asserted mid-frame flushes the pipeline immediately: the next-cycle outputs are reset values.
- frame_start together with rst: rst wins.

## Test plan
- Reset: hold rst 2 cycles with random inputs, then release → pix_out=0, pix_out_valid=0, collide=0, rom_addr=0. First valid pixel appears exactly 2 cycles after the first pix_valid.
- Double buffer: live spr_x[0]=100, frame_start, then change live to 300 mid-frame. Pixel (110,y0) → sprite colour. Pixel (310,y0) → BG_C until the next frame_start.
- Orientation: sprite 0 at (64,64), dir 0..3, pixel (65,66) → rom_addr = 34, 61, 65, 94 respectively (SPR_W=32).
- Priority/transparency: sprites 0 and 1 overlap; rom_data0=KEY, rom_data1=12'h0f0 → 12'h0f0. With rom_data0=12'hf00 → 12'hf00. is_bean=1 → 12'hff0. over=1 → 12'h000.
- Edge clip: spr_x=620, SPR_W=32, col 639 → hit with ox=19. col 0..11 → no hit (no wrap).
- Collision: opaque overlap of sprites 0 and 2 for one pixel → collide=1 after the next frame_start. A frame with no overlap → collide=0 after the following frame_start. An overlap coinciding with frame_start → reported one frame later.
